// File: rtl/bcd_display_mux_if.sv
// Purpose: bundles the display-mux data path (counter digits in, display drive out) so the
//          producer side and the display driver can be wired with one connection.
// Signals:
//   en        scan enable (low freezes scan and turns every digit off)
//   blank_lz  blank leading zeros of hundreds/tens
//   d_u/d_t/d_h  BCD digits from the counter (units/tens/hundreds)
//   seg       segments {g,f,e,d,c,b,a}
//   an        digit enables {hund,tens,units}
//   frame     one-cycle pulse when a new digit snapshot is taken
//   err       snapshot holds a code above 9
// Modports: master = counter/stimulus side, slave = display driver.
interface bcd_display_mux_if;
  logic       en;
  logic       blank_lz;
  logic [3:0] d_u;
  logic [3:0] d_t;
  logic [3:0] d_h;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame;
  logic       err;

  modport master (
    output en,
    output blank_lz,
    output d_u,
    output d_t,
    output d_h,
    input  seg,
    input  an,
    input  frame,
    input  err
  );

  modport slave (
    input  en,
    input  blank_lz,
    input  d_u,
    input  d_t,
    input  d_h,
    output seg,
    output an,
    output frame,
    output err
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Purpose: time-multiplexed 3-digit 7-segment driver for a 000-999 BCD counter. A prescaler
//          divides clk into digit slots; the scan walks units -> tens -> hundreds. Digits are
//          snapshotted once per frame so a counter update never tears the displayed value.
//          Each slot begins with one all-off cycle to suppress ghosting.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-high
//   io_disp  slave modport of bcd_display_mux_if:
//              en, blank_lz, d_u, d_t, d_h  (inputs)
//              seg[6:0], an[2:0], frame, err (registered outputs)
// Parameters:
//   CLK_DIV      clk cycles per digit slot (>= 2)
//   SEG_ACT_LOW  1: segment outputs active-low
//   AN_ACT_LOW   1: digit enables active-low
module bcd_display_mux #(
  parameter int unsigned CLK_DIV     = 16,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  bcd_display_mux_if.slave io_disp
);

  localparam int unsigned     CntW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [6:0]      SegOff = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]      AnOff  = AN_ACT_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    IdxUnits = 2'd0,
    IdxTens  = 2'd1,
    IdxHund  = 2'd2
  } idx_e;

  // Active-high glyphs, gfedcba; any non-BCD code shows 'E'.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h79;
    endcase
    return g;
  endfunction

  // State
  logic [CntW-1:0] r_cnt;
  idx_e            r_idx;
  logic            r_started;  // first frame snapshot taken since reset
  logic [3:0]      r_s_u;
  logic [3:0]      r_s_t;
  logic [3:0]      r_s_h;
  logic [6:0]      r_seg;
  logic [2:0]      r_an;
  logic            r_frame;
  logic            r_err;

  // Next-state helpers
  logic       w_tick;
  logic       w_frame_start;
  idx_e       w_idx_next;
  logic [3:0] w_digit;
  logic       w_blank;
  logic [6:0] w_seg_hi;
  logic [6:0] w_seg_drv;
  logic [2:0] w_an_hi;
  logic [2:0] w_an_drv;
  logic       w_err_next;

  always_comb begin
    // en gates the tick, so a tick coinciding with en falling never advances the scan.
    w_tick        = io_disp.en && (r_cnt == CntMax);
    // The very first tick after reset starts a frame at UNITS instead of advancing.
    w_frame_start = w_tick && (!r_started || (r_idx == IdxHund));

    w_idx_next = IdxUnits;
    if (!w_frame_start) begin
      case (r_idx)
        IdxUnits: w_idx_next = IdxTens;
        IdxTens:  w_idx_next = IdxHund;
        default:  w_idx_next = IdxUnits;
      endcase
    end

    w_digit = r_s_u;
    w_an_hi = 3'b001;
    case (r_idx)
      IdxTens: begin
        w_digit = r_s_t;
        w_an_hi = 3'b010;
      end
      IdxHund: begin
        w_digit = r_s_h;
        w_an_hi = 3'b100;
      end
      default: begin
        w_digit = r_s_u;
        w_an_hi = 3'b001;
      end
    endcase

    // Only genuine zeros are blanked, so an invalid code always stays visible.
    w_blank = io_disp.blank_lz &&
              (((r_idx == IdxHund) && (r_s_h == 4'd0)) ||
               ((r_idx == IdxTens) && (r_s_h == 4'd0) && (r_s_t == 4'd0)));

    w_seg_hi  = seg_decode(w_digit);
    w_seg_drv = w_blank ? SegOff : (SEG_ACT_LOW ? ~w_seg_hi : w_seg_hi);
    w_an_drv  = AN_ACT_LOW ? ~w_an_hi : w_an_hi;

    w_err_next = (io_disp.d_u > 4'd9) || (io_disp.d_t > 4'd9) || (io_disp.d_h > 4'd9);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= IdxUnits;
      r_started <= 1'b0;
      r_s_u     <= 4'd0;
      r_s_t     <= 4'd0;
      r_s_h     <= 4'd0;
      r_seg     <= SegOff;
      r_an      <= AnOff;
      r_frame   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (!io_disp.en) begin
        // Frozen: prescaler and scan hold, display dark until enable returns.
        r_an  <= AnOff;
        r_seg <= SegOff;
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + CntW'(1);
        if (w_tick) begin
          // Slot boundary: one dark cycle before the next digit lights.
          r_idx <= w_idx_next;
          r_an  <= AnOff;
          r_seg <= SegOff;
          if (w_frame_start) begin
            r_started <= 1'b1;
            r_s_u     <= io_disp.d_u;
            r_s_t     <= io_disp.d_t;
            r_s_h     <= io_disp.d_h;
            r_frame   <= 1'b1;
            r_err     <= w_err_next;
          end
        end else if (r_started) begin
          // Refreshed every cycle so a blank_lz change shows within the slot.
          r_an  <= w_an_drv;
          r_seg <= w_seg_drv;
        end
      end
    end
  end

  assign io_disp.seg   = r_seg;
  assign io_disp.an    = r_an;
  assign io_disp.frame = r_frame;
  assign io_disp.err   = r_err;

endmodule
